// File: rtl/decision_gate_ctrl.sv
// Purpose: adaptive inner-level gate for the 16-QAM slicer; it measures the mean |I|/|Q| over N symbols.
// Latency: gates, upd and locked update at the edge that samples the window-closing bitsync.
// Backpressure: none. Every bitsync in ACQ/TRACK is consumed, and strobes may arrive on back-to-back cycles.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   en                acquisition enable (level)
//   bitsync, di, dq   symbol strobe and signed I/Q samples
//   gate_up/gate_down registered +/- inner-level thresholds
//   locked, upd       last window valid; one-cycle gate-update pulse
module decision_gate_ctrl #(
    parameter int DW           = 27,
    parameter int LOG2N        = 8,
    parameter int DEFAULT_GATE = 3000000,
    parameter int MIN_GATE     = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          bitsync,
    input  logic [DW-1:0] di,
    input  logic [DW-1:0] dq,
    output logic [DW-1:0] gate_up,
    output logic [DW-1:0] gate_down,
    output logic          locked,
    output logic          upd
);

    localparam int AW = DW - 1 + LOG2N;   // per-channel accumulator, N samples of DW-1 bits
    localparam int SW = DW + LOG2N;       // I+Q window sum

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    state_t           state, state_n;
    logic [LOG2N-1:0] cnt, cnt_n;
    logic [AW-1:0]    acc_i, acc_i_n, acc_q, acc_q_n;
    logic [DW-1:0]    gate_n;
    logic             locked_n, upd_n;

    logic [AW-1:0]    acc_i_sum, acc_q_sum;
    logic [SW-1:0]    win_sum;
    logic [DW-2:0]    mean;
    logic             unused_win_lsbs;

    // Magnitude of a signed sample. The most negative code saturates to the
    // largest positive value, so the result always fits in DW-1 bits.
    function automatic logic [DW-2:0] mag(input logic [DW-1:0] x);
        logic [DW-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[DW-1])
            mag = x[DW-2:0];
        else if (x[DW-2:0] == '0)
            mag = '1;
        else
            mag = neg[DW-2:0];
    endfunction

    // The running sums include the current strobe, so the closing window
    // contains its own last sample.
    assign acc_i_sum = acc_i + AW'(mag(di));
    assign acc_q_sum = acc_q + AW'(mag(dq));
    assign win_sum   = SW'(acc_i_sum) + SW'(acc_q_sum);
    // Dividing by 2N averages |I| and |Q| together.
    assign mean      = win_sum[SW-1:LOG2N+1];
    assign unused_win_lsbs = ^win_sum[LOG2N:0];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_i_n  = acc_i;
        acc_q_n  = acc_q;
        gate_n   = gate_up;
        locked_n = locked;
        upd_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n    = '0;
                acc_i_n  = '0;
                acc_q_n  = '0;
                locked_n = 1'b0;
                if (en)
                    state_n = ACQ;
            end
            ACQ, TRACK: begin
                if (!en) begin
                    // Abort discards the partial window. The gates keep their value.
                    state_n  = IDLE;
                    cnt_n    = '0;
                    acc_i_n  = '0;
                    acc_q_n  = '0;
                    locked_n = 1'b0;
                end else if (bitsync) begin
                    cnt_n   = cnt + 1'b1;
                    acc_i_n = acc_i_sum;
                    acc_q_n = acc_q_sum;
                    if (cnt == '1) begin
                        acc_i_n = '0;
                        acc_q_n = '0;
                        if (mean >= (DW-1)'(MIN_GATE)) begin
                            gate_n   = {1'b0, mean};
                            upd_n    = 1'b1;
                            locked_n = 1'b1;
                            state_n  = TRACK;
                        end else begin
                            // Signal loss: keep the last good gate and reacquire.
                            locked_n = 1'b0;
                            state_n  = ACQ;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
            gate_up <= DW'(DEFAULT_GATE);
            locked  <= 1'b0;
            upd     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            acc_i   <= acc_i_n;
            acc_q   <= acc_q_n;
            gate_up <= gate_n;
            locked  <= locked_n;
            upd     <= upd_n;
        end
    end

    // gate_down is derived from the gate_up register, so the two always agree.
    assign gate_down = -gate_up;

endmodule

// File: tb/tb_decision_gate_ctrl.sv
module tb_decision_gate_ctrl;

    localparam int     DW    = 27;
    localparam int     LOG2N = 2;
    localparam int     N     = 4;
    localparam longint DEF   = 3000000;
    localparam longint MING  = 100000;
    localparam longint MAXM  = 67108863;   // 2^26-1

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              bitsync = 1'b0;
    logic signed [DW-1:0] di = '0;
    logic signed [DW-1:0] dq = '0;
    logic signed [DW-1:0] gate_up, gate_down;
    logic              locked, upd;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    bit chk_on = 1'b0;

    decision_gate_ctrl #(
        .DW(DW), .LOG2N(LOG2N), .DEFAULT_GATE(3000000), .MIN_GATE(100000)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .bitsync(bitsync), .di(di), .dq(dq),
        .gate_up(gate_up), .gate_down(gate_down), .locked(locked), .upd(upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint amag(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        if (m > MAXM) m = MAXM;
        return m;
    endfunction

    // Reference model: a window is the list of per-symbol |I|+|Q| values.
    // When N are collected, the mean is their total divided by 2N.
    bit       m_active = 1'b0;
    bit       m_locked = 1'b0;
    bit       m_upd    = 1'b0;
    longint   m_gate   = DEF;
    longint   win_q[$];

    always @(posedge clk) begin
        longint tot;
        m_upd = 1'b0;
        if (!rst) begin
            m_gate = DEF; m_locked = 1'b0; m_active = 1'b0; win_q.delete();
        end else if (!m_active) begin
            m_locked = 1'b0; win_q.delete();
            if (en) m_active = 1'b1;
        end else if (!en) begin
            m_active = 1'b0; m_locked = 1'b0; win_q.delete();
        end else if (bitsync) begin
            win_q.push_back(amag(longint'(di)) + amag(longint'(dq)));
            if (win_q.size() == N) begin
                tot = 0;
                foreach (win_q[k]) tot += win_q[k];
                win_q.delete();
                if (tot / (2 * N) >= MING) begin
                    m_gate = tot / (2 * N); m_upd = 1'b1; m_locked = 1'b1;
                end else begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            if (upd === 1'b1) upd_cnt++;
            chk("gate_up", longint'(gate_up), m_gate);
            chk("gate_down", longint'(gate_down), -m_gate);
            chk("locked", longint'(locked), longint'(m_locked));
            chk("upd", longint'(upd), longint'(m_upd));
        end
    end

    task automatic cyc(input bit r, input bit e, input bit b, input longint i, input longint q);
        @(negedge clk);
        rst = r; en = e; bitsync = b; di = i[DW-1:0]; dq = q[DW-1:0];
    endtask

    // n strobes, spaced or back-to-back, then two quiet cycles so outputs settle.
    task automatic win(input int n, input longint i, input longint q, input bit b2b);
        for (int k = 0; k < n; k++) begin
            cyc(1, 1, 1, i, q);
            if (!b2b) cyc(1, 1, 0, 0, 0);
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
    endtask

    function automatic longint rnd_sample();
        longint v;
        case ($urandom_range(0, 3))
            0:       v = longint'($urandom_range(0, 150000));
            1:       v = longint'($urandom_range(0, 67108863));
            2:       v = 67108864;
            default: v = longint'($urandom_range(0, 10000000));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    initial begin
        int base;
        bit r_en;
        // Reset held three cycles, then released with en low.
        cyc(0, 0, 1, 5000000, 5000000);
        chk_on = 1'b1;
        cyc(0, 0, 1, 5000000, 5000000);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 1, 7000000, 7000000);
        chk("reset gate_up", longint'(gate_up), 3000000);
        chk("reset gate_down", longint'(gate_down), -3000000);
        chk("reset locked", longint'(locked), 0);
        chk("reset upd count", longint'(upd_cnt), 0);

        // Acquisition: three strobes change nothing, the fourth closes the window.
        cyc(1, 1, 0, 0, 0);
        base = upd_cnt;
        win(3, 9000000, -3000000, 1'b0);
        chk("acq partial gate", longint'(gate_up), 3000000);
        chk("acq partial upd", longint'(upd_cnt - base), 0);
        win(1, 9000000, -3000000, 1'b0);
        chk("acq gate_up", longint'(gate_up), 6000000);
        chk("acq gate_down", longint'(gate_down), -6000000);
        chk("acq locked", longint'(locked), 1);
        chk("acq upd count", longint'(upd_cnt - base), 1);

        // Tracking: spaced and back-to-back strobes give the same result.
        base = upd_cnt;
        win(4, -3000000, 1000000, 1'b0);
        chk("track gate", longint'(gate_up), 2000000);
        chk("track upd count", longint'(upd_cnt - base), 1);
        win(4, 9000000, -3000000, 1'b1);
        chk("b2b gate a", longint'(gate_up), 6000000);
        win(4, -3000000, 1000000, 1'b1);
        chk("b2b gate b", longint'(gate_up), 2000000);

        // Signal loss, then relock.
        base = upd_cnt;
        win(4, 50000, 50000, 1'b0);
        chk("loss gate", longint'(gate_up), 2000000);
        chk("loss locked", longint'(locked), 0);
        chk("loss upd count", longint'(upd_cnt - base), 0);
        win(4, 9000000, -3000000, 1'b1);
        chk("relock gate", longint'(gate_up), 6000000);
        chk("relock locked", longint'(locked), 1);

        // Saturation of the most negative sample.
        win(4, -67108864, -67108864, 1'b1);
        chk("sat gate", longint'(gate_up), 67108863);
        chk("sat gate_down", longint'(gate_down), -67108863);

        // Abort via en: the partial window must be discarded.
        win(2, 20000000, 20000000, 1'b0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 20000000, 20000000);
        cyc(1, 1, 0, 0, 0);
        base = upd_cnt;
        win(4, 4000000, 4000000, 1'b0);
        chk("abort gate", longint'(gate_up), 4000000);
        chk("abort upd count", longint'(upd_cnt - base), 1);

        // en drops on a window-closing strobe: no update.
        win(3, 8000000, 8000000, 1'b0);
        cyc(1, 0, 1, 8000000, 8000000);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("en-drop close gate", longint'(gate_up), 4000000);

        // Reset mid-window restores the default gate at the next edge.
        cyc(1, 1, 0, 0, 0);
        win(2, 5000000, 5000000, 1'b0);
        cyc(0, 1, 1, 5000000, 5000000);
        cyc(1, 1, 0, 0, 0);
        chk("rst mid gate_up", longint'(gate_up), 3000000);
        chk("rst mid gate_down", longint'(gate_down), -3000000);
        chk("rst mid locked", longint'(locked), 0);

        // Randomized traffic; the per-cycle comparison against the model does the checking.
        r_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) r_en = ~r_en;
            cyc(($urandom_range(0, 199) != 0), r_en, ($urandom_range(0, 9) < 6),
                rnd_sample(), rnd_sample());
        end
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decision_gate_ctrl.md
# decision_gate_ctrl

Adaptive threshold controller for the 16-QAM symbol decision slicer in the receive chain. It watches the same `di`/`dq` samples and `bitsync` strobe that feed the slicer and measures the mean absolute I/Q amplitude over a window of N symbols. It drives the slicer's positive and negative inner-level gates from that measurement, replacing the fixed ±3000000 constants, and flags lock once a valid window has been measured.

## Interface
- `DW`, 27: sample width, signed two's complement
- `LOG2N`, 8: log2 of window length N in symbols (N=256)
- `DEFAULT_GATE`, 3000000: gate value after reset and before the first valid window
- `MIN_GATE`, 100000: smallest measured gate accepted; anything below it is treated as signal loss

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `en`  in  1  acquisition enable; level-sensitive
- `bitsync`  in  1  symbol strobe; one-cycle pulse per symbol
- `di`  in  DW  signed I sample, valid when `bitsync`=1
- `dq`  in  DW  signed Q sample, valid when `bitsync`=1
- `gate_up`  out  DW  signed positive inner-level threshold
- `gate_down`  out  DW  signed negative threshold; always equals −`gate_up`
- `locked`  out  1  high while the last completed window was valid
- `upd`  out  1  one-cycle pulse when `gate_up`/`gate_down` take a new value

## Operation
- Absolute value: |x| = x if x≥0, else −x. The most negative input, −2^(DW−1), saturates to 2^(DW−1)−1.
- Accumulators:
  - `acc_i` and `acc_q` are unsigned, DW−1+LOG2N bits each, so they cannot overflow over N samples.
  - Symbol counter `cnt` is LOG2N bits.
- Window result: mean = (acc_i + acc_q) >> (LOG2N+1), using a DW+LOG2N-bit sum. This is the average of |I| and |Q|. For ideal ±1/±3 levels the result falls exactly on the inner/outer boundary.
- State machine has three states: IDLE, ACQ, TRACK.
- IDLE:
  - `cnt`, `acc_i`, `acc_q` are cleared; `locked`=0.
  - Gates hold their current value.
  - Goes to ACQ on the cycle `en`=1 is sampled. A `bitsync` in that same cycle is ignored.
- ACQ and TRACK:
  - Each `bitsync`=1 adds |di| to `acc_i`, adds |dq| to `acc_q`, and increments `cnt`.
  - On the strobe that brings `cnt` from N−1 to wrap (0), the window closes. Accumulators restart from zero and this strobe's sample is included in the closing window.
- Window close with mean ≥ MIN_GATE:
  - `gate_up`←mean, `gate_down`←−mean, `upd`=1 for one cycle, `locked`←1.
  - State becomes or stays TRACK.
- Window close with mean < MIN_GATE:
  - Gates are unchanged, `upd`=0, `locked`←0.
  - State becomes ACQ.
- `en`=0 in ACQ or TRACK: go to IDLE on the next edge. Any partial window is discarded and the gates retain their last value.
- `rst`=0 has priority over everything and applies at the next edge, including mid-window:
  - `gate_up`=DEFAULT_GATE, `gate_down`=−DEFAULT_GATE.
  - `locked`=0, `upd`=0.
  - State IDLE; `cnt` and accumulators = 0.

## Timing
- All outputs are registered.
- Latency: `gate_up`/`gate_down`/`upd`/`locked` change at the edge that samples the window-closing `bitsync`. They are visible in the following cycle, before the next strobe.
- Because of this, the slicer's next symbol always sees the new gate. A gate never changes between a sample and its own decision.
- `bitsync` on consecutive cycles is legal. Every strobe counts, one sample per cycle.
- `en` falling on the same cycle as a window-closing strobe: the `en`=0 action wins, with no update and no `upd` pulse.
- `bitsync` while in IDLE or while `rst`=0 is ignored.
- `gate_down` is derived from the same register as `gate_up` (negation). It can never disagree with `gate_up` in any cycle.

## Test plan
Benches use LOG2N=2 (N=4) unless stated otherwise.

- **Reset:** hold `rst`=0 for 3 cycles, then release with `en`=0 → `gate_up`=3000000, `gate_down`=−3000000, `locked`=0, `upd` never pulses.
- **Acquisition:** `en`=1, then 4 strobes of `di`=+9000000, `dq`=−3000000 → after the 4th strobe, `gate_up`=6000000, `gate_down`=−6000000, a single `upd` pulse, `locked`=1. With only 3 strobes there is no change.
- **Tracking:** continue with 4 strobes of `di`=−3000000, `dq`=+1000000 → `gate_up`=2000000 with one `upd`. Also check that back-to-back strobes on consecutive cycles produce the identical result.
- **Signal loss:** in TRACK, send 4 strobes of `di`=`dq`=50000 → gates stay at their previous value, `locked`=0, no `upd`, state ACQ. A following valid window relocks.
- **Saturation:** 4 strobes of `di`=`dq`=−2^26 → `gate_up`=67108863, with no accumulator overflow.
- **Abort:**
  - Drop `en` after 2 of 4 strobes, re-enable, then send 4 strobes of 4000000 → `gate_up`=4000000, showing the partial window was discarded.
  - Pull `rst`=0 mid-window → DEFAULT_GATE is restored at the next edge.
